// File: rtl/riscy_pkg.sv
// Shared opcode constants and ALU/branch encodings for the decode stage and ALU.
package riscy_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_EQ   = 2'b01,
    BR_NE   = 2'b10
  } branch_e;

endpackage

// File: rtl/decode_stage_regfile.sv
// 2R1W register file: x0 reads zero, writeback value bypasses to same-cycle reads.
module regfile #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];

  // Next register contents: apply the writeback, never to x0.
  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0) mem_d[waddr] = wdata;
  end

  // Storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous reads with x0 forced to zero and write-through bypass.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) rdata1 = (we && waddr == raddr1) ? wdata : mem_q[raddr1];
    if (raddr2 != '0) rdata2 = (we && waddr == raddr2) ? wdata : mem_q[raddr2];
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I ALU/branch-subset decode and operand fetch with busy-bit hazard stalls.
module decode_stage
  import riscy_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  input  logic [31:0]     instr,
  output logic            instr_ready,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [2:0]      ex_ctrl,
  output logic [4:0]      ex_rd_addr,
  output logic            ex_we,
  output logic [1:0]      ex_branch,
  output logic [XLEN-1:0] ex_br_off,
  input  logic            wb_valid,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  localparam int unsigned AW = $clog2(NREGS);

  logic [6:0] opcode;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic [2:0] f3;
  logic [6:0] f7;
  assign opcode = instr[6:0];
  assign rd_f   = instr[11:7];
  assign f3     = instr[14:12];
  assign rs1_f  = instr[19:15];
  assign rs2_f  = instr[24:20];
  assign f7     = instr[31:25];

  logic [XLEN-1:0] imm_i, imm_b, rdata1, rdata2;
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_b = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

  regfile #(.XLEN(XLEN), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (rs1_f[AW-1:0]),
    .raddr2 (rs2_f[AW-1:0]),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_valid),
    .waddr  (wb_addr[AW-1:0]),
    .wdata  (wb_data)
  );

  logic      legal, we_dec, use_rs2, use_imm;
  alu_ctrl_e ctrl_dec;
  branch_e   br_dec;

  // Decode the supported subset; anything else is flagged illegal.
  always_comb begin
    legal    = 1'b0;
    we_dec   = 1'b0;
    use_rs2  = 1'b0;
    use_imm  = 1'b0;
    ctrl_dec = ALU_ADD;
    br_dec   = BR_NONE;
    case (opcode)
      OP_R: begin
        legal   = 1'b1;
        we_dec  = 1'b1;
        use_rs2 = 1'b1;
        case ({f7, f3})
          {7'b0000000, 3'b000}: ctrl_dec = ALU_ADD;
          {7'b0100000, 3'b000}: ctrl_dec = ALU_SUB;
          {7'b0000000, 3'b111}: ctrl_dec = ALU_AND;
          {7'b0000000, 3'b110}: ctrl_dec = ALU_OR;
          {7'b0000000, 3'b010}: ctrl_dec = ALU_SLT;
          default:              legal    = 1'b0;
        endcase
      end
      OP_IMM: begin
        legal   = 1'b1;
        we_dec  = 1'b1;
        use_imm = 1'b1;
        case (f3)
          3'b000:  ctrl_dec = ALU_ADD;
          3'b111:  ctrl_dec = ALU_AND;
          3'b110:  ctrl_dec = ALU_OR;
          3'b010:  ctrl_dec = ALU_SLT;
          default: legal    = 1'b0;
        endcase
      end
      OP_BRANCH: begin
        legal    = 1'b1;
        use_rs2  = 1'b1;
        ctrl_dec = ALU_SUB;
        case (f3)
          3'b000:  br_dec = BR_EQ;
          3'b001:  br_dec = BR_NE;
          default: legal  = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  logic [NREGS-1:0] busy_q, busy_d;
  logic             rs1_haz, rs2_haz, rd_haz, stall, accept;

  // Hazard check: a busy register stalls unless writeback frees it this cycle.
  always_comb begin
    rs1_haz     = rs1_f != '0 && busy_q[rs1_f] && !(wb_valid && wb_addr == rs1_f);
    rs2_haz     = rs2_f != '0 && busy_q[rs2_f] && !(wb_valid && wb_addr == rs2_f);
    rd_haz      = rd_f  != '0 && busy_q[rd_f]  && !(wb_valid && wb_addr == rd_f);
    stall       = instr_valid && legal && (rs1_haz || (use_rs2 && rs2_haz) || (we_dec && rd_haz));
    instr_ready = !stall && (!ex_valid || ex_ready);
    accept      = instr_valid && instr_ready;
  end

  logic            ex_valid_q, ex_valid_d, ex_we_q, ex_we_d, illegal_q, illegal_d;
  logic [XLEN-1:0] ex_rs1_q, ex_rs1_d, ex_rs2_q, ex_rs2_d, ex_br_off_q, ex_br_off_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  alu_ctrl_e       ex_ctrl_q, ex_ctrl_d;
  branch_e         ex_br_q, ex_br_d;

  // Output bundle and scoreboard next state; a set of busy[rd] overrides a same-cycle clear.
  always_comb begin
    ex_valid_d  = ex_valid_q;
    ex_rs1_d    = ex_rs1_q;
    ex_rs2_d    = ex_rs2_q;
    ex_ctrl_d   = ex_ctrl_q;
    ex_rd_d     = ex_rd_q;
    ex_we_d     = ex_we_q;
    ex_br_d     = ex_br_q;
    ex_br_off_d = ex_br_off_q;
    illegal_d   = accept && !legal;
    busy_d      = busy_q;
    if (accept && legal) begin
      ex_valid_d  = 1'b1;
      ex_rs1_d    = rdata1;
      ex_rs2_d    = use_imm ? imm_i : rdata2;
      ex_ctrl_d   = ctrl_dec;
      ex_rd_d     = we_dec ? rd_f : '0;
      ex_we_d     = we_dec;
      ex_br_d     = br_dec;
      ex_br_off_d = (br_dec != BR_NONE) ? imm_b : '0;
    end else if (ex_ready) begin
      ex_valid_d = 1'b0;
    end
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (accept && legal && we_dec && rd_f != '0) busy_d[rd_f] = 1'b1;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_ctrl_q   <= ALU_ADD;
      ex_rd_q     <= '0;
      ex_we_q     <= 1'b0;
      ex_br_q     <= BR_NONE;
      ex_br_off_q <= '0;
      illegal_q   <= 1'b0;
      busy_q      <= '0;
    end else begin
      ex_valid_q  <= ex_valid_d;
      ex_rs1_q    <= ex_rs1_d;
      ex_rs2_q    <= ex_rs2_d;
      ex_ctrl_q   <= ex_ctrl_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_br_q     <= ex_br_d;
      ex_br_off_q <= ex_br_off_d;
      illegal_q   <= illegal_d;
      busy_q      <= busy_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs1     = ex_rs1_q;
  assign ex_rs2     = ex_rs2_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_rd_addr = ex_rd_q;
  assign ex_we      = ex_we_q;
  assign ex_branch  = ex_br_q;
  assign ex_br_off  = ex_br_off_q;
  assign illegal    = illegal_q;

endmodule
